multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM that sequences the shared RV32I datapath (program counter, instruction/data memory, register file, immediate extender, ALU) over multiple cycles per instruction.
- Replaces the hard-wired enables/selects in the single-cycle top. Drives all mux selects, write enables and ALU control, and waits on a ready handshake from the unified memory port.
- Supports lw, sw, R-type ALU, I-type ALU, lui, beq/bne and jal. Any other encoding traps.

Parameters:
- RESET_STATE_DBG, 1, when 1 the `state` debug output is driven; when 0 it is tied to 0.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- instr  input  32  current instruction-register contents
- zero  input  1  ALU result == 0
- mem_ready  input  1  memory accepted/completed the current request this cycle
- mem_req  output  1  memory access request, held until mem_ready
- mem_write  output  1  request is a store; valid only with mem_req
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU-out register
- ir_write  output  1  load instruction register
- pc_write  output  1  load PC from result bus
- reg_write  output  1  register-file write enable
- alu_src_a  output  2  0 = PC, 1 = old PC, 2 = rs1, 3 = zero
- alu_src_b  output  2  0 = rs2, 1 = immediate, 2 = constant 4
- result_src  output  2  0 = ALU-out register, 1 = memory read data, 2 = ALU result (combinational)
- alu_control  output  4  ALU operation encoding (package)
- imm_sel  output  3  immediate format: I = 0, S = 1, B = 2, U = 3, J = 4
- illegal  output  1  sticky trap flag
- state  output  4  debug: current FSM state

Behaviour:
- Reset (rst low at a clock edge): state = FETCH, illegal = 0.
  - All enables (mem_req, mem_write, ir_write, pc_write, reg_write) are 0 in the reset cycle.
  - All selects are 0; alu_control = ADD; imm_sel = I.
- Outputs are a Moore decode of state, except:
  - pc_write in FETCH, which is gated by mem_ready;
  - pc_write in BRANCH, which depends on zero and funct3;
  - alu_control in EXEC_R/EXEC_I, which is decoded from funct3/funct7.
- FETCH:
  - mem_req = 1, adr_src = 0, a = PC, b = 4, ADD, result_src = 2.
  - When mem_ready: ir_write = 1, pc_write = 1, go to DECODE. Otherwise hold; all writes stay 0.
- DECODE:
  - a = old PC, b = imm, ADD. Computes the branch/jal target into the ALU-out register.
  - imm_sel = B for opcode 1100011, J otherwise.
  - Next state by opcode:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0110111 → LUI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - anything else → TRAP
- MEMADR:
  - a = rs1, b = imm, ADD; imm_sel = S for stores, I for loads.
  - Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req = 1, adr_src = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src = 1, reg_write = 1 → FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. Wait for mem_ready, then go to FETCH.
- EXEC_R: a = rs1, b = rs2.
  - ALU op from funct3, with funct7[5] selecting SUB/SRA.
  - → ALUWB.
- EXEC_I: a = rs1, b = imm (I).
  - funct7[5] is used only for SRAI; ADDI never subtracts.
  - → ALUWB.
- LUI: a = zero, b = imm (U), ADD → ALUWB.
- ALUWB: result_src = 0, reg_write = 1 → FETCH.
- BRANCH: a = rs1, b = rs2, SUB, result_src = 0.
  - pc_write = (funct3 == 000 & zero) | (funct3 == 001 & ~zero).
  - Any other funct3 → TRAP with no write. Otherwise → FETCH.
- JAL: pc_write = 1 with result_src = 0 (target). a = old PC, b = 4, ADD → ALUWB, which writes the link.
- TRAP: illegal = 1, all enables 0, stays in TRAP until reset.
- Latency with zero-wait memory, in cycles:
  - branch: 3
  - R-type, I-type, lui, sw, jal: 4
  - lw: 5
  - Each mem_ready-low cycle adds one.
- Handshake rules:
  - mem_req and adr_src are stable while waiting.
  - A transfer completes on the edge where mem_req and mem_ready are both high.
  - mem_ready outside a request is ignored.
- Reset mid-instruction or while waiting: state → FETCH next edge. No pending write completes.
- Unrecognised funct3 in EXEC_R/EXEC_I maps to ADD. Only opcode and branch-funct3 trap.

Decomposition:
- Shared package `rv32i_pkg` holds:
  - state enum;
  - opcode constants;
  - ALU encodings: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8, SLTU 9;
  - imm_sel encodings;
  - src-mux encodings.
- One sub-module, `alu_decoder` (combinational: op-class, funct3, funct7[5] → alu_control), reused by a future pipelined core.

Test Plan:
- Reset low mid-MEMREAD, then release → next state FETCH, illegal = 0, no reg_write/mem_write pulse.
- instr 0x002081B3 (add x3,x1,x2), mem_ready always 1 → FETCH, DECODE, EXEC_R (alu_control = ADD), ALUWB with reg_write = 1; 4 cycles.
- instr 0x00802283 (lw x5,8(x0)), mem_ready low 2 cycles in MEMREAD → mem_req held with adr_src = 1 for 3 cycles; MEMWB result_src = 1, reg_write = 1; 7 cycles total.
- instr 0x00502623 (sw x5,12(x0)) → MEMADR imm_sel = S; MEMWRITE mem_req = mem_write = 1; no reg_write anywhere.
- instr 0x00000463 (beq x0,x0,8), zero = 1 → BRANCH pc_write = 1, alu_control = SUB. Same with zero = 0 → pc_write = 0. Both 3 cycles.
- instr 0x00000000 → TRAP after DECODE, illegal = 1 and held for 100 cycles, no enables; clears only on rst low.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcodes,
// ALU operations, immediate formats and datapath mux selects.
package rv32i_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_LUI      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_RS1   = 2'd2,
        SRCA_ZERO  = 2'd3
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'd0,
        RES_MEMDATA   = 2'd1,
        RES_ALURESULT = 2'd2
    } result_src_e;

    // Operation class handed to the ALU decoder by the controlling FSM.
    typedef enum logic [1:0] {
        ALUOP_ADD = 2'd0,
        ALUOP_SUB = 2'd1,
        ALUOP_R   = 2'd2,
        ALUOP_I   = 2'd3
    } alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// Maps an operation class plus funct3/funct7[5] to an ALU control code.
// Kept standalone so a pipelined core can reuse it in its decode stage.
module alu_decoder
    import rv32i_pkg::*;
(
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_ctrl_e  alu_control_o
);

    // funct7[5] only means SUB for register-register ops; immediates use it solely for SRAI.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            default: begin
                case (funct3_i)
                    3'b000:  alu_control_o = (alu_op_i == ALUOP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_o = ALU_SLL;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b011:  alu_control_o = ALU_SLTU;
                    3'b100:  alu_control_o = ALU_XOR;
                    3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences the shared datapath and the unified
// memory port, trapping on unsupported opcodes or branch conditions.
module multicycle_controller
    import rv32i_pkg::*;
#(
    parameter bit RESET_STATE_DBG = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_sel,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    alu_op_e    alu_op;
    alu_ctrl_e  alu_ctrl;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign funct7b5          = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are forced to their idle values while rst is low so that no
    // pending write or memory request escapes during the reset cycle.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        imm_sel    = IMM_I;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = (opcode == OP_BRANCH) ? IMM_B : IMM_J;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_LUI:            state_d = S_LUI;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        default:           state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = RES_MEMDATA;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_R;
                    state_d   = S_ALUWB;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_I;
                    state_d   = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    imm_sel   = IMM_U;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    state_d   = S_FETCH;
                    case (funct3)
                        3'b000:  pc_write = zero;
                        3'b001:  pc_write = ~zero;
                        default: state_d  = S_TRAP;
                    endcase
                end
                // Target was computed in DECODE; this cycle forms PC+4 for the link.
                S_JAL: begin
                    pc_write  = 1'b1;
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    state_d   = S_ALUWB;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_ctrl)
    );

    assign alu_control = alu_ctrl;
    assign illegal     = illegal_q;
    assign state       = RESET_STATE_DBG ? state_q : 4'd0;

endmodule
